// File: rtl/clkdiv_gen.sv
// ---------------------------------------------------------------------------
// clkdiv_gen
//
// On-fabric integer clock divider bank. From a single reference clock it
// produces NUM_CH phase-aligned divided clocks (outclk) and matching
// one-cycle tick enables (tick). Each channel's divisor can be changed at run
// time through a one-deep request slot. The request takes effect on the
// channel's own period boundary, so the output never has a runt or stretched
// phase. After reset the outputs stay quiet until a fixed settle count has
// elapsed. Then locked rises and every channel starts together at phase 0.
//
// Ports
//   refclk     in   reference clock; all logic runs on it
//   rst_n      in   asynchronous active-low reset (release is synchronous)
//   cfg_valid  in   reconfiguration request valid
//   cfg_ready  out  block can accept a request this cycle
//   cfg_ch     in   [CH_W]  target channel of the request
//   cfg_div    in   [DIV_W] new divisor (1..2^DIV_W-1)
//   cfg_err    out  one-cycle pulse: the request accepted last cycle was bad
//   sync_req   in   restart every channel at phase 0 (ignored until locked)
//   outclk     out  [NUM_CH] registered divided clocks
//   tick       out  [NUM_CH] one-cycle pulse at each outclk rising edge
//   locked     out  outputs are valid and running
//
// Request handshake: a request transfers on every refclk edge where
// cfg_valid && cfg_ready are both high. The requester must hold cfg_ch and
// cfg_div stable while cfg_valid is high. A request naming a missing channel
// or a zero divisor is consumed and flagged on cfg_err in the next cycle,
// with no other effect. A good request occupies the pending slot and drops
// cfg_ready. cfg_ready comes back in the cycle after the divisor is applied.
// ---------------------------------------------------------------------------
module clkdiv_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int CH_W        = 2,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = 24'h050102
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  // Settle counter reaches LOCK_CYCLES on the locking edge, so it needs one
  // extra code beyond LOCK_CYCLES-1.
  localparam int SET_W = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Lock state machine
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SET_W-1:0] settle_q;
  logic [SET_W-1:0] settle_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        settle_d = settle_q;
      end
      default: begin
        state_d = ST_SETTLE;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  logic run_q;   // locked in the current cycle
  logic run_d;   // locked in the next cycle

  assign run_q  = (state_q == ST_LOCKED);
  assign run_d  = (state_d == ST_LOCKED);
  assign locked = run_q;

  // -------------------------------------------------------------------------
  // Request intake and pending slot
  // -------------------------------------------------------------------------
  logic             pend_valid_q;
  logic             pend_valid_d;
  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             req_fire;
  logic             req_bad;
  logic [31:0]      ch_ext;
  logic             apply_any;

  // Channel compare is done at 32 bits so that it is also correct when
  // NUM_CH is a power of two and every cfg_ch code is a real channel.
  assign ch_ext   = 32'(cfg_ch);
  assign req_fire = cfg_valid && cfg_ready;
  assign req_bad  = (cfg_div == '0) || (ch_ext >= 32'(NUM_CH));

  // A good request can only arrive while the slot is empty (cfg_ready is
  // low while it is full). Acceptance and apply therefore never collide.
  assign pend_valid_d = (pend_valid_q && !apply_any) || (req_fire && !req_bad);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      cfg_ready    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      if (req_fire && !req_bad) begin
        pend_ch_q  <= cfg_ch;
        pend_div_q <= cfg_div;
      end
      cfg_ready <= !pend_valid_d;
      cfg_err   <= req_fire && req_bad;
    end
  end

  // -------------------------------------------------------------------------
  // Channel counters
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] div_d  [NUM_CH];
  logic [DIV_W:0]   high_d [NUM_CH];
  logic [NUM_CH-1:0] apply_ch;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] outclk_d;
  logic [NUM_CH-1:0] tick_d;

  always_comb begin
    apply_any = 1'b0;
    apply_ch  = '0;
    restart   = '0;
    outclk_d  = '0;
    tick_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      div_d[c]  = div_q[c];
      high_d[c] = '0;
      if (run_q) begin
        // Last count of the period, or a global restart: next cycle is
        // phase 0. This is also the only point where a new divisor may
        // take effect, so the period in flight always completes.
        restart[c]  = sync_req || (cnt_q[c] == div_q[c] - 1'b1);
        apply_ch[c] = pend_valid_q && (pend_ch_q == CH_W'(c)) && restart[c];
        cnt_d[c]    = restart[c] ? '0 : cnt_q[c] + 1'b1;
      end else begin
        // No output phase to protect before lock: apply straight away and
        // keep the counter parked at 0 so all channels start aligned.
        apply_ch[c] = pend_valid_q && (pend_ch_q == CH_W'(c));
        cnt_d[c]    = '0;
      end
      if (apply_ch[c]) begin
        div_d[c]  = pend_div_q;
        apply_any = 1'b1;
      end
      // High time is ceil(D/2). Outputs are computed from next-state values
      // and registered, so they line up with the counter without any
      // combinational path to the pins.
      high_d[c]   = ({1'b0, div_d[c]} + 1'b1) >> 1;
      outclk_d[c] = run_d && ({1'b0, cnt_d[c]} < high_d[c]);
      tick_d[c]   = run_d && (cnt_d[c] == '0);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= DEFAULT_DIV[c*DIV_W +: DIV_W];
      end
      outclk <= '0;
      tick   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
      end
      outclk <= outclk_d;
      tick   <= tick_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_gen.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_gen
//
// Bench for clkdiv_gen with default parameters. The reference model tracks,
// for each channel, the cycle number where its current period series began
// and its divisor. Phase is then (now - start) mod divisor. Directed
// tables and sequences cover lock timing, free run, retune, errors, sync
// and reset. A randomized run checks every cycle against the model.
// ---------------------------------------------------------------------------
module tb_clkdiv_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int CH_W        = 2;
  localparam int LOCK_CYCLES = 16;

  // Clock / reset
  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  // DUT signals
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
  logic              cfg_err;
  logic              sync_req  = 1'b0;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  clkdiv_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W),
    .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_DIV(24'h050102)
  ) dut (
    .refclk(refclk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .sync_req(sync_req), .outclk(outclk), .tick(tick), .locked(locked)
  );

  // Scoreboard counters and expected queue
  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int t;                 // cycles since reset release
  int t0 [NUM_CH];       // cycle where the current period series began
  int d  [NUM_CH];       // divisor in force
  bit m_locked, m_ready, m_err;
  bit pv;
  int pch, pd;

  task automatic model_reset();
    t = 0; m_locked = 0; m_ready = 0; m_err = 0; pv = 0; pch = 0; pd = 0;
    d[0] = 2; d[1] = 1; d[2] = 5;
    for (int c = 0; c < NUM_CH; c++) t0[c] = 0;
  endtask

  // Called at each active edge with the inputs that were presented.
  task automatic model_edge();
    bit take, reject;
    int ph;
    take   = cfg_valid && m_ready && (cfg_div != 0) && (int'(cfg_ch) < NUM_CH);
    reject = cfg_valid && m_ready && !take;
    if (m_locked) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph = (t - t0[c]) % d[c];
        if (sync_req || ph == d[c] - 1) begin
          t0[c] = t + 1;
          if (pv && pch == c) begin
            d[c] = pd;
            pv   = 0;
          end
        end
      end
    end else begin
      if (pv) begin
        d[pch] = pd;
        pv     = 0;
      end
      if (t + 1 == LOCK_CYCLES) begin
        m_locked = 1;
        for (int c = 0; c < NUM_CH; c++) t0[c] = t + 1;
      end
    end
    if (take) begin
      pv = 1; pch = int'(cfg_ch); pd = int'(cfg_div);
    end
    m_ready = !pv;
    m_err   = reject;
    t++;
  endtask

  task automatic model_check();
    logic [NUM_CH-1:0] eo, et;
    int ph;
    eo = '0; et = '0;
    if (m_locked) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph    = (t - t0[c]) % d[c];
        eo[c] = (ph < (d[c] + 1) / 2);
        et[c] = (ph == 0);
      end
    end
    chk("mdl_outclk", 32'(outclk), 32'(eo));
    chk("mdl_tick", 32'(tick), 32'(et));
    chk("mdl_locked", 32'(locked), 32'(m_locked));
    chk("mdl_cfg_ready", 32'(cfg_ready), 32'(m_ready));
    chk("mdl_cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic cyc();
    @(posedge refclk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_outclk", 32'(outclk), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    repeat (n) @(posedge refclk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic settle_check();
    for (int k = 1; k <= LOCK_CYCLES; k++) begin
      cyc();
      chk("lock_timing", 32'(locked), 32'(k == LOCK_CYCLES));
      if (k == 1) chk("ready_after_release", 32'(cfg_ready), 1);
    end
    chk("first_lock_outclk", 32'(outclk), 32'h7);
    chk("first_lock_tick", 32'(tick), 32'h7);
  endtask

  // Free-run vectors: sync_req driven during cycle i, outputs expected in
  // cycle i+1 (cycle 0 is the first locked cycle, defaults 2/1/5).
  typedef struct {
    logic       sync;
    logic [2:0] exp_outclk;
    logic [2:0] exp_tick;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 3'b110, 3'b010};
    vecs[1] = '{1'b0, 3'b111, 3'b011};
    vecs[2] = '{1'b0, 3'b010, 3'b010};
    vecs[3] = '{1'b0, 3'b011, 3'b011};
    vecs[4] = '{1'b0, 3'b110, 3'b110};
    vecs[5] = '{1'b1, 3'b111, 3'b111};   // sync on ch0 boundary
    vecs[6] = '{1'b0, 3'b110, 3'b010};
    vecs[7] = '{1'b0, 3'b111, 3'b011};
    vecs[8] = '{1'b1, 3'b111, 3'b111};   // sync mid-period
    vecs[9] = '{1'b0, 3'b110, 3'b010};

    // Reset and settle
    @(posedge refclk);
    hold_reset(3);
    settle_check();

    // Table-driven free run
    for (int i = 0; i < 10; i++) begin
      sync_req = vecs[i].sync;
      cyc();
      sync_req = 1'b0;
      chk("vec_outclk", 32'(outclk), 32'(vecs[i].exp_outclk));
      chk("vec_tick", 32'(tick), 32'(vecs[i].exp_tick));
    end

    // ch2 is at phase 1: retune to 4; period of 5 finishes, then 1,1,0,0
    chk("retune_ready_before", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4;
    cyc();
    cfg_valid = 1'b0;
    // {cfg_ready, tick[2], outclk[2]}
    exp_q.push_back(3'b001); exp_q.push_back(3'b000); exp_q.push_back(3'b000);
    exp_q.push_back(3'b111); exp_q.push_back(3'b101); exp_q.push_back(3'b100);
    exp_q.push_back(3'b100); exp_q.push_back(3'b111);
    while (exp_q.size() > 0) begin
      chk("ch2_retune", 32'({cfg_ready, tick[2], outclk[2]}), 32'(exp_q.pop_front()));
      cyc();
    end

    // Rejected requests: zero divisor, then missing channel
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    cyc();
    cfg_valid = 1'b0;
    chk("err_div0_pulse", 32'(cfg_err), 1);
    chk("err_div0_ready", 32'(cfg_ready), 1);
    cyc();
    chk("err_div0_clear", 32'(cfg_err), 0);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
    cyc();
    cfg_valid = 1'b0;
    chk("err_ch3_pulse", 32'(cfg_err), 1);
    chk("err_ch3_ready", 32'(cfg_ready), 1);
    cyc();
    chk("err_ch3_clear", 32'(cfg_err), 0);

    // Align, then sync with ch0 div=6 pending (ch0 at phase 0, not boundary)
    sync_req = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    cyc();
    cfg_valid = 1'b0;
    chk("sync_pending_ready", 32'(cfg_ready), 0);
    cyc();
    sync_req = 1'b0;
    chk("sync_outclk", 32'(outclk), 32'h7);
    chk("sync_tick", 32'(tick), 32'h7);
    chk("sync_ready_back", 32'(cfg_ready), 1);
    exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    while (exp_q.size() > 0) begin
      chk("ch0_div6", 32'(outclk[0]), 32'(exp_q.pop_front()));
      cyc();
    end

    // Reset with a request pending; it must not survive
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd9;
    cyc();
    cfg_valid = 1'b0;
    hold_reset(2);
    settle_check();
    exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    while (exp_q.size() > 0) begin
      chk("ch2_default_after_rst", 32'(outclk[2]), 32'(exp_q.pop_front()));
      cyc();
    end

    // Randomized run against the model, with one reset in the middle
    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)       cfg_div = 8'd0;
      else if ($urandom_range(0, 19) == 0) cfg_div = DIV_W'($urandom_range(10, 40));
      else                                 cfg_div = DIV_W'($urandom_range(1, 9));
      sync_req = ($urandom_range(0, 39) == 0);
      if (n == 1500) hold_reset(2);
      cyc();
    end
    cfg_valid = 1'b0;
    sync_req  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_gen.md
Name: clkdiv_gen

Overview:
- Parametrised on-fabric clock generator. It derives NUM_CH phase-aligned divided clocks and per-channel tick enables from refclk.
- Per-channel divisors are runtime-reprogrammable. A locked indication follows a power-up settle count.
- Sits beside the vendor PLL wrapper. Serves peripherals (UART baud, VGA pixel, timers) that need integer-ratio clocks or enables retuned by the CPU without re-running the PLL flow.

Parameters:
- NUM_CH, 3, number of output channels (1..16).
- DIV_W, 8, divisor width; legal divisor range 1..2^DIV_W-1.
- CH_W, 2, width of the channel select, ceil(log2(NUM_CH)) with minimum 1.
- LOCK_CYCLES, 16, refclk cycles after reset release before locked asserts (>=1).
- DEFAULT_DIV, 24'h050102, packed reset divisors, ch0 in LSBs: ch0=2, ch1=1, ch2=5.

Ports:
- refclk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  reconfiguration request valid.
- cfg_ready  out  1  block can accept a request.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  new divisor.
- cfg_err  out  1  one-cycle pulse: the accepted request was rejected.
- sync_req  in  1  pulse; restart all channels at phase 0.
- outclk  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle pulse at each rising edge of outclk[c].
- locked  out  1  outputs valid and running.

Behaviour:
- Reset (async assert, sync release):
  - outclk=0, tick=0, locked=0, cfg_err=0, cfg_ready=0.
  - Divisors load from DEFAULT_DIV; all channel counters = 0; settle counter = 0; pending slot empty.
- Settle:
  - Counts refclk edges with rst_n high.
  - The cycle after the LOCK_CYCLES-th edge: locked=1, and every channel is at phase 0.
  - cfg_ready=1 from the first edge after reset release.
- Channel c, divisor D, high time H=ceil(D/2):
  - Counter cnt runs 0..D-1 and wraps.
  - outclk[c]=1 while cnt<H, else 0. tick[c]=1 only when cnt==0.
  - D=1: outclk constant 1 and tick constant 1 while locked.
  - Example D=5: outclk = 1,1,1,0,0 repeating.
  - Outputs are driven from registers, with no combinational path from the counter.
  - While locked=0: outclk=0, tick=0, counters held at 0.
- Handshake:
  - A request is accepted on an edge where cfg_valid&&cfg_ready.
  - If cfg_div==0 or cfg_ch>=NUM_CH: cfg_err=1 on the next cycle, no state change, cfg_ready stays 1.
  - Otherwise the request fills the single pending slot and cfg_ready=0 until it is applied.
  - cfg_ready returns to 1 the cycle after the apply cycle.
- Apply rules:
  - Locked: the pending divisor is applied at the channel's period boundary. On the edge where cnt==D_old-1, the next cycle is phase 0 of the new divisor; no runt or stretched phase.
  - Not locked: applied on the edge after acceptance.
  - Other channels are unaffected.
- Sync:
  - sync_req sampled high while locked: the next cycle all channels are at cnt=0 (all outclk=1, tick=1).
  - A pending request applies at that same restart.
  - sync_req while unlocked is ignored.
  - sync_req coinciding with a period boundary: sync wins; the result is identical phase 0.
- Reset mid-operation: the pending request is discarded, divisors revert to DEFAULT_DIV, and the settle count restarts.
- locked never drops after asserting, except on reset.

Test Plan:
- Release reset with LOCK_CYCLES=16 -> locked rises exactly 16 edges after release; first locked cycle outclk=3'b111, tick=3'b111.
- Free run with defaults -> ch0 1,0 period 2; ch1 constant 1; ch2 1,1,1,0,0 period 5; tick[2] every 5 cycles.
- With ch2 at cnt=1, write ch2 div=4 -> cfg_ready=0; current period finishes (3 more cycles); then 1,1,0,0 repeating; cfg_ready=1 one cycle after apply.
- Write div=0, then ch=3 -> one-cycle cfg_err pulse each; divisors unchanged; cfg_ready stays 1.
- Pending ch0 div=6 (current ch0 div=2) when sync_req pulses -> next cycle all channels at phase 0; ch0 runs with div 6 from that cycle.
- Assert rst_n low mid-pending, release -> outputs 0 immediately; defaults restored; locked after 16 edges; no stale apply.
